// File: rtl/i2s_pkg.sv
// Shared constants, mode encoding and the slot bit-position helper for the I2S transmitter.
package i2s_pkg;

  typedef enum logic [1:0] {
    MODE_I2S = 2'd0,
    MODE_LJ  = 2'd1,
    MODE_RJ  = 2'd2
  } i2s_mode_e;

  localparam int unsigned DEF_DATA_W     = 24;
  localparam int unsigned DEF_SLOT_W     = 32;
  localparam int unsigned DEF_BCLK_DIV   = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // Word bit carried at in-slot position p, or -1 when the slot is padding there.
  // The reserved encoding falls through to I2S alignment.
  function automatic int bit_index(input logic [1:0] mode, input int p,
                                   input int dw, input int sw);
    int k;
    k = -1;
    case (mode)
      MODE_LJ: if (p < dw) k = dw - 1 - p;
      MODE_RJ: if (p >= sw - dw) k = sw - 1 - p;
      default: if (p >= 1 && p <= dw) k = dw - p;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (do_pop && !do_push) level <= level - (AW+1)'(1);
    end
  end

  // Storage needs no reset: pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/i2s_stream_tx.sv
// Stereo sample FIFO feeding an I2S / left- / right-justified serial frame engine (BCLK master).
module i2s_stream_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned SLOT_W     = DEF_SLOT_W,
  parameter int unsigned BCLK_DIV   = DEF_BCLK_DIV,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [1:0]                    mode,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data_l,
  input  logic [DATA_W-1:0]             s_data_r,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic                          frame_start,
  input  logic                          underrun_clr,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DIV_W  = $clog2(BCLK_DIV);
  localparam int unsigned BIT_W  = $clog2(2 * SLOT_W);
  localparam int unsigned PAIR_W = 2 * DATA_W;
  localparam int unsigned IDX_W  = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_W);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d, div_step;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [PAIR_W-1:0] hold_q, hold_d;
  logic [1:0]        mode_q, mode_d;
  logic              bclk_d, lrclk_d, sdata_d, fs_d, underrun_d, s_ready_d;
  logic              fall_c, start_c, shift_c, pop_c, push_c, underrun_set_c;
  logic [LVL_W-1:0]  lvl_d;
  logic [DATA_W-1:0] word;
  int                p;
  int                k;

  logic [PAIR_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;

  assign push_c = s_valid && s_ready && !fifo_full;

  sync_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   ({s_data_l, s_data_r}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Frame engine: BCLK divider, bit sequencing, frame pops and serial bit selection.
  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    bit_d          = bit_q;
    hold_d         = hold_q;
    mode_d         = mode_q;
    bclk_d         = 1'b0;
    lrclk_d        = lrclk;
    sdata_d        = sdata;
    fs_d           = 1'b0;
    start_c        = 1'b0;
    shift_c        = 1'b0;
    pop_c          = 1'b0;
    underrun_set_c = 1'b0;
    word           = '0;
    p              = 0;
    k              = -1;
    fall_c         = (div_q == DIV_LAST);
    div_step       = fall_c ? '0 : div_q + DIV_W'(1);

    case (state_q)
      ST_RUN: begin
        div_d  = div_step;
        bclk_d = (div_step >= DIV_HALF);
        if (fall_c) begin
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + BIT_W'(1);
            shift_c = 1'b1;
          end else if (enable) begin
            bit_d   = '0;
            start_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
            bit_d   = '0;
            div_d   = '0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
            hold_d  = '0;
          end
        end
      end
      default: begin
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        if (enable) begin
          div_d  = div_step;
          bclk_d = (div_step >= DIV_HALF);
          if (fall_c) begin
            state_d = ST_RUN;
            bit_d   = '0;
            start_c = 1'b1;
          end
        end else begin
          div_d = '0;
        end
      end
    endcase

    // An empty FIFO at frame start yields a silent frame.
    if (start_c) begin
      pop_c          = 1'b1;
      fs_d           = 1'b1;
      mode_d         = mode;
      hold_d         = fifo_empty ? '0 : fifo_rdata;
      underrun_set_c = fifo_empty;
    end

    if (start_c || shift_c) begin
      lrclk_d = (bit_d >= BIT_SLOT);
      p       = lrclk_d ? int'(bit_d) - int'(SLOT_W) : int'(bit_d);
      word    = lrclk_d ? hold_d[DATA_W-1:0] : hold_d[PAIR_W-1:DATA_W];
      k       = bit_index(mode_d, p, int'(DATA_W), int'(SLOT_W));
      sdata_d = (k >= 0) ? word[k[IDX_W-1:0]] : 1'b0;
    end

    underrun_d = underrun_set_c ? 1'b1 : (underrun_clr ? 1'b0 : underrun);

    lvl_d = fifo_level;
    if (push_c && !(pop_c && !fifo_empty))      lvl_d = fifo_level + LVL_W'(1);
    else if (!push_c && pop_c && !fifo_empty)   lvl_d = fifo_level - LVL_W'(1);
    s_ready_d = (lvl_d != FULL_LVL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      hold_q      <= '0;
      mode_q      <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      s_ready     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      hold_q      <= hold_d;
      mode_q      <= mode_d;
      bclk        <= bclk_d;
      lrclk       <= lrclk_d;
      sdata       <= sdata_d;
      frame_start <= fs_d;
      underrun    <= underrun_d;
      s_ready     <= s_ready_d;
    end
  end

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Directed bench for i2s_stream_tx: default stereo instance plus a DATA_W=16/SLOT_W=20/BCLK_DIV=2 instance.
module tb_i2s_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset_n, enable, s_valid, underrun_clr;
  logic [1:0]  mode;
  logic [23:0] s_data_l, s_data_r;
  logic        s_ready, bclk, lrclk, sdata, frame_start, underrun;
  logic [2:0]  fifo_level;

  logic        en2, sv2, clr2;
  logic [1:0]  mode2;
  logic [15:0] dl2, dr2;
  logic        rdy2, bclk2, lr2, sd2, fs2, ur2;
  logic [1:0]  lvl2;

  int total = 0;
  int bad   = 0;

  i2s_stream_tx u_dut (
    .clk (clk), .reset_n (reset_n), .enable (enable), .mode (mode),
    .s_valid (s_valid), .s_ready (s_ready), .s_data_l (s_data_l), .s_data_r (s_data_r),
    .bclk (bclk), .lrclk (lrclk), .sdata (sdata), .frame_start (frame_start),
    .underrun_clr (underrun_clr), .underrun (underrun), .fifo_level (fifo_level)
  );

  i2s_stream_tx #(.DATA_W (16), .SLOT_W (20), .BCLK_DIV (2), .FIFO_DEPTH (2)) u_dut2 (
    .clk (clk), .reset_n (reset_n), .enable (en2), .mode (mode2),
    .s_valid (sv2), .s_ready (rdy2), .s_data_l (dl2), .s_data_r (dr2),
    .bclk (bclk2), .lrclk (lr2), .sdata (sd2), .frame_start (fs2),
    .underrun_clr (clr2), .underrun (ur2), .fifo_level (lvl2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push1(input logic [23:0] l, input logic [23:0] r);
    s_data_l = l;
    s_data_r = r;
    s_valid  = 1'b1;
    @(negedge clk);
    s_valid  = 1'b0;
  endtask

  task automatic wait_fs(input int which, input int budget, output int waited);
    logic seen;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < budget) begin
      @(negedge clk);
      waited++;
      seen = (which == 1) ? frame_start : fs2;
    end
    check("frame_start_seen", 64'(seen), 64'd1);
  endtask

  // Samples sdata/lrclk once per bit starting at the frame_start sample point; first bit lands in the MSB.
  task automatic capture(input int which, input int nbits, input int div,
                         output logic [63:0] bits, output logic [63:0] lrs);
    bits = '0;
    lrs  = '0;
    for (int b = 0; b < nbits; b++) begin
      bits = {bits[62:0], (which == 1) ? sdata : sd2};
      lrs  = {lrs[62:0],  (which == 1) ? lrclk : lr2};
      if (b != nbits - 1) repeat (div) @(negedge clk);
    end
  endtask

  initial begin
    logic [63:0] bits, lrs;
    int w, t_prev, rises, fs_cnt;
    logic prev_bclk;

    reset_n = 1'b0; enable = 1'b0; mode = 2'd0; s_valid = 1'b0; underrun_clr = 1'b0;
    s_data_l = '0; s_data_r = '0;
    en2 = 1'b0; sv2 = 1'b0; clr2 = 1'b0; mode2 = 2'd0; dl2 = '0; dr2 = '0;

    repeat (2) @(negedge clk);
    check("rst_bclk",     64'(bclk), 64'd0);
    check("rst_lrclk",    64'(lrclk), 64'd0);
    check("rst_sdata",    64'(sdata), 64'd0);
    check("rst_fs",       64'(frame_start), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_level",    64'(fifo_level), 64'd0);
    check("rst_s_ready",  64'(s_ready), 64'd0);
    check("rst_bclk2",    64'(bclk2), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst", 64'(s_ready), 64'd1);

    // Fill the FIFO while disabled; one entry per mode under test.
    push1(24'hABCDEF, 24'h123456);
    push1(24'h800001, 24'hFFFFFF);
    push1(24'h800001, 24'hFFFFFF);
    push1(24'h000001, 24'h800000);
    check("full_level",   64'(fifo_level), 64'd4);
    check("full_s_ready", 64'(s_ready), 64'd0);
    push1(24'h111111, 24'h222222);
    check("push_while_full_level", 64'(fifo_level), 64'd4);

    mode = 2'd0;
    enable = 1'b1;
    wait_fs(1, 20, w);
    check("start_latency", 64'(w), 64'd4);
    check("pop_level",     64'(fifo_level), 64'd3);
    check("pop_s_ready",   64'(s_ready), 64'd1);
    t_prev = cyc;
    capture(1, 64, 4, bits, lrs);
    check("i2s_frame", bits, 64'h55E6F780_091A2B00);
    check("i2s_lrclk", lrs,  64'h00000000_FFFFFFFF);

    mode = 2'd1;
    wait_fs(1, 20, w);
    check("frame_period", 64'(cyc - t_prev), 64'd256);
    check("level_f2", 64'(fifo_level), 64'd2);
    capture(1, 64, 4, bits, lrs);
    check("lj_frame", bits, 64'h80000100_FFFFFF00);
    check("lj_p0",  64'(bits[63]), 64'd1);
    check("lj_p23", 64'(bits[40]), 64'd1);

    mode = 2'd2;
    wait_fs(1, 20, w);
    check("level_f3", 64'(fifo_level), 64'd1);
    capture(1, 64, 4, bits, lrs);
    check("rj_frame", bits, 64'h00800001_00FFFFFF);

    mode = 2'd3;
    wait_fs(1, 20, w);
    check("level_f4", 64'(fifo_level), 64'd0);
    capture(1, 64, 4, bits, lrs);
    check("reserved_as_i2s", bits, 64'h00000080_40000000);
    check("no_underrun_yet", 64'(underrun), 64'd0);

    mode = 2'd0;
    wait_fs(1, 20, w);
    check("underrun_set", 64'(underrun), 64'd1);
    capture(1, 64, 4, bits, lrs);
    check("underrun_frame_zero", bits, 64'd0);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun_cleared", 64'(underrun), 64'd0);

    underrun_clr = 1'b1;
    wait_fs(1, 20, w);
    underrun_clr = 1'b0;
    check("underrun_set_beats_clr", 64'(underrun), 64'd1);

    // Disable right after a frame starts: that frame completes, then the lines park low.
    enable = 1'b0;
    rises = 0;
    fs_cnt = 0;
    prev_bclk = bclk;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bclk && !prev_bclk) rises++;
      if (frame_start) fs_cnt++;
      prev_bclk = bclk;
    end
    check("disable_bclk_rises", 64'(rises), 64'd64);
    check("disable_no_fs", 64'(fs_cnt), 64'd0);
    check("idle_bclk",  64'(bclk), 64'd0);
    check("idle_lrclk", 64'(lrclk), 64'd0);
    check("idle_sdata", 64'(sdata), 64'd0);

    push1(24'hABCDEF, 24'h654321);
    push1(24'h555555, 24'h333333);
    check("idle_push_level", 64'(fifo_level), 64'd2);

    enable = 1'b1;
    wait_fs(1, 20, w);
    check("restart_level", 64'(fifo_level), 64'd1);
    repeat (40 * 4 + 2) @(negedge clk);
    check("bit40_lrclk", 64'(lrclk), 64'd1);
    check("bit40_sdata", 64'(sdata), 64'd1);
    check("bit40_bclk",  64'(bclk), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_bclk",     64'(bclk), 64'd0);
    check("midrst_lrclk",    64'(lrclk), 64'd0);
    check("midrst_sdata",    64'(sdata), 64'd0);
    check("midrst_underrun", 64'(underrun), 64'd0);
    check("midrst_level",    64'(fifo_level), 64'd0);
    check("midrst_s_ready",  64'(s_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_fs(1, 20, w);
    check("post_rst_latency",  64'(w), 64'd4);
    check("post_rst_underrun", 64'(underrun), 64'd1);
    check("post_rst_level",    64'(fifo_level), 64'd0);
    check("post_rst_lrclk",    64'(lrclk), 64'd0);
    enable = 1'b0;

    // Narrow instance: 16-bit samples in 20-bit slots, BCLK = clk/2.
    dl2 = 16'hA5C3;
    dr2 = 16'h1234;
    sv2 = 1'b1;
    @(negedge clk);
    sv2 = 1'b0;
    check("p2_level", 64'(lvl2), 64'd1);
    en2 = 1'b1;
    wait_fs(2, 20, w);
    t_prev = cyc;
    capture(2, 40, 2, bits, lrs);
    check("p2_i2s_frame", bits, 64'h00000052_E18091A0);
    check("p2_lrclk",     lrs,  64'h00000000_000FFFFF);
    wait_fs(2, 20, w);
    check("p2_frame_period", 64'(cyc - t_prev), 64'd80);
    check("p2_underrun", 64'(ur2), 64'd1);
    check("p2_s_ready",  64'(rdy2), 64'd1);
    en2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_stream_tx.md
I2S_STREAM_TX -- requirements
Module: i2s_stream_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 24: sample width per channel, 8..32.
REQ-002 SHALL have parameter SLOT_W, default 32: BCLK periods per channel slot; SLOT_W > DATA_W is required.
REQ-003 SHALL have parameter BCLK_DIV, default 4: clk cycles per BCLK period; must be even and >= 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: stereo-pair FIFO entries; must be a power of 2 and >= 2.
REQ-005 SHALL have port clk, input, 1: codec master clock (12 MHz domain).
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port enable, input, 1: run the serial frame engine.
REQ-008 SHALL have port mode, input, 2: 0 = I2S, 1 = left-justified, 2 = right-justified, 3 = reserved (treated as I2S).
REQ-009 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_data_l (input, DATA_W) and s_data_r (input, DATA_W): stereo sample push.
REQ-010 SHALL have outputs bclk, lrclk and sdata, each 1 bit: serial audio lines.
REQ-011 SHALL have output frame_start, 1: one-clk pulse when a new frame's left slot begins.
REQ-012 SHALL have input underrun_clr (1) and output underrun (1): sticky underrun flag and its clear.
REQ-013 SHALL have output fifo_level, $clog2(FIFO_DEPTH)+1 bits: count of FIFO entries.

Function
REQ-014 SHALL push {s_data_l, s_data_r} on a clk edge where s_valid && s_ready; s_ready = (fifo_level != FIFO_DEPTH), so there are no pushes when full.
REQ-015 SHALL generate BCLK from div_cnt, which counts 0..BCLK_DIV-1; bclk = 1 when div_cnt >= BCLK_DIV/2, giving a 50% duty cycle.
REQ-016 SHALL update bit_cnt (0..2*SLOT_W-1, wrapping), lrclk and sdata only on the clk edge where div_cnt wraps to 0 (the BCLK falling edge).
REQ-017 SHALL drive lrclk = 0 for bit_cnt < SLOT_W (left slot) and lrclk = 1 otherwise.
REQ-018 SHALL, at the falling edge where bit_cnt becomes 0, pop one FIFO entry into the shift holding register, pulse frame_start, and latch mode for the whole frame.
REQ-019 SHALL, with in-slot position p = bit_cnt mod SLOT_W, drive sdata from word bit k, MSB first.
- I2S: k = DATA_W-p for p in 1..DATA_W.
- Left-justified: k = DATA_W-1-p for p in 0..DATA_W-1.
- Right-justified: k = SLOT_W-1-p for p in SLOT_W-DATA_W..SLOT_W-1.
- All other positions: sdata = 0.
REQ-020 SHALL transmit an all-zero frame and set underrun on a frame pop with the FIFO empty; underrun stays set until an underrun_clr pulse.
REQ-021 SHALL give set priority when an underrun event and underrun_clr occur in the same cycle.
REQ-022 SHALL apply a simultaneous push and pop in the same cycle, leaving fifo_level unchanged; a push while full is not possible.
REQ-023 SHALL start the engine with enable high at div_cnt = 0 and bit_cnt = 0 (a pop occurs on the first falling edge).
REQ-024 SHALL, on enable deassertion, finish the current frame, then hold bclk, lrclk and sdata at 0; the FIFO keeps accepting pushes.
REQ-025 SHALL insert no extra BCLK gaps between consecutive frames while enable stays high.

Reset
REQ-026 SHALL, on reset_n low, immediately force bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, fifo_level=0 and s_ready=0, and clear div_cnt, bit_cnt, the FIFO pointers and the holding register.
REQ-027 SHALL raise s_ready in the first clk after reset_n deasserts, and SHALL discard any in-flight frame or FIFO content when reset occurs mid-operation.

Structure
REQ-028 SHALL place the mode enum (I2S, LJ, RJ) and the default parameter constants in package i2s_pkg.
REQ-029 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, level).

Verification
REQ-030 SHALL cover I2S stereo (defaults): push L=0xABCDEF, R=0x123456 -> left-slot bits 1..24 = 0xABCDEF MSB-first, bits 0 and 25..31 = 0; right slot likewise 0x123456; frame = 256 clk.
REQ-031 SHALL cover left-justified and right-justified: mode=1 with L=0x800001 -> sdata=1 at p=0 and at p=23; mode=2 -> sdata=1 at p=8 and at p=31.
REQ-032 SHALL cover underrun: no pushes after a frame -> next frame all zeros, underrun=1; pulse underrun_clr -> underrun=0; same-cycle set and clear -> underrun=1.
REQ-033 SHALL cover FIFO full: push 4 pairs while disabled -> fifo_level=4, s_ready=0; enable -> a pop at the first frame_start gives level 3 and s_ready=1.
REQ-034 SHALL cover reset mid-frame: assert reset_n at bit 40 -> all outputs 0 within the same clk; after release the first frame starts at bit 0 with an empty FIFO (underrun).
REQ-035 SHALL cover parameter sweep: DATA_W=16, SLOT_W=16... is illegal; DATA_W=16, SLOT_W=20, BCLK_DIV=2 -> frame = 80 clk, with I2S bit alignment per REQ-019.
